// File: rtl/cpu_types_pkg.sv
// Shared MIPS pipeline types: ALU opcodes, word/register types, forwarding selects
// and small instruction-field helpers.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  // Shifts move portA by portB[4:0]; SLT/SLTU return 1 or 0 in bit 0.
  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_t;

  localparam regbits_t RA_REG = 5'd31;

  function automatic regbits_t rsField(input word_t instr);
    return instr[25:21];
  endfunction

  function automatic regbits_t rtField(input word_t instr);
    return instr[20:16];
  endfunction

  function automatic regbits_t rdField(input word_t instr);
    return instr[15:11];
  endfunction

endpackage

// File: rtl/alu.sv
// Pipeline ALU: 32-bit wrapping arithmetic and logic, overflow ignored.
module alu
  import cpu_types_pkg::*;
(
  input  word_t  portA,
  input  word_t  portB,
  input  aluop_t aluop,
  output word_t  outputPort
);

  always_comb begin
    outputPort = '0;
    case (aluop)
      ALU_SLL:  outputPort = portA << portB[4:0];
      ALU_SRL:  outputPort = portA >> portB[4:0];
      ALU_ADD:  outputPort = portA + portB;
      ALU_SUB:  outputPort = portA - portB;
      ALU_AND:  outputPort = portA & portB;
      ALU_OR:   outputPort = portA | portB;
      ALU_XOR:  outputPort = portA ^ portB;
      ALU_NOR:  outputPort = ~(portA | portB);
      ALU_SLT:  outputPort = {31'd0, $signed(portA) < $signed(portB)};
      ALU_SLTU: outputPort = {31'd0, portA < portB};
      default:  outputPort = '0;
    endcase
  end

endmodule

// File: rtl/exmem_stage.sv
// Execute stage and EX/MEM latch: operand forwarding, ALU, branch/jump redirect,
// load-use detection, and the registered hand-off to the memory stage.
module exmem_stage
  import cpu_types_pkg::*;
#(
  parameter regbits_t RA_REG    = cpu_types_pkg::RA_REG,
  parameter word_t    RESET_PC4 = 32'h0
)
(
  input  logic         CLK,
  input  logic         RST,
  input  logic         validEX,
  input  aluop_t       opEX,
  input  logic [31:0]  rdat1EX,
  input  logic [31:0]  rdat2EX,
  input  logic [31:0]  immEX,
  input  logic [31:0]  pcEX,
  input  logic [31:0]  instrEX,
  input  logic         jmpEX,
  input  logic         jmprEX,
  input  logic         j_alEX,
  input  logic         b_eqEX,
  input  logic         b_neEX,
  input  logic         alu_srcEX,
  input  logic         l_uiEX,
  input  logic         reg_dstEX,
  input  logic         rf_writeEX,
  input  logic         memtoregEX,
  input  logic         dRENEX,
  input  logic         dWENEX,
  input  logic         haltEX,
  input  logic         hold,
  input  logic         flush,
  input  logic         wb_wen,
  input  logic [4:0]   wb_wsel,
  input  logic [31:0]  wb_wdat,
  output logic         redirect,
  output logic [31:0]  redirect_pc,
  output logic         lu_stall,
  output logic         validMEM,
  output logic         rf_writeMEM,
  output logic         memtoregMEM,
  output logic         dRENMEM,
  output logic         dWENMEM,
  output logic         haltMEM,
  output logic [31:0]  aluresMEM,
  output logic [31:0]  storedatMEM,
  output logic [4:0]   wselMEM,
  output logic [31:0]  pcplus4MEM,
  output logic         halted
);

  regbits_t rsIdx, rtIdx, rdIdx, exWsel;
  fwd_sel_t fwdSelA, fwdSelB;
  word_t    opA, rtVal, opB, aluOut, exResult;
  word_t    pcPlus4, branchTarget, jumpTarget;
  logic     memFwdOk, takeBranch, bubble;
  logic     unusedOpcode;

  assign rsIdx        = rsField(instrEX);
  assign rtIdx        = rtField(instrEX);
  assign rdIdx        = rdField(instrEX);
  assign unusedOpcode = ^instrEX[31:26];

  // A load in MEM has no data yet, so it never forwards; it stalls instead.
  assign memFwdOk = validMEM && rf_writeMEM && !memtoregMEM;

  always_comb begin
    fwdSelA = FWD_NONE;
    fwdSelB = FWD_NONE;
    if (memFwdOk && wselMEM == rsIdx && rsIdx != '0)
      fwdSelA = FWD_MEM;
    else if (wb_wen && wb_wsel == rsIdx && rsIdx != '0)
      fwdSelA = FWD_WB;
    if (memFwdOk && wselMEM == rtIdx && rtIdx != '0)
      fwdSelB = FWD_MEM;
    else if (wb_wen && wb_wsel == rtIdx && rtIdx != '0)
      fwdSelB = FWD_WB;
  end

  always_comb begin
    case (fwdSelA)
      FWD_MEM: opA = aluresMEM;
      FWD_WB:  opA = wb_wdat;
      default: opA = rdat1EX;
    endcase
    case (fwdSelB)
      FWD_MEM: rtVal = aluresMEM;
      FWD_WB:  rtVal = wb_wdat;
      default: rtVal = rdat2EX;
    endcase
  end

  assign opB = alu_srcEX ? immEX : rtVal;

  alu u_alu (
    .portA      (opA),
    .portB      (opB),
    .aluop      (opEX),
    .outputPort (aluOut)
  );

  assign pcPlus4      = pcEX + 32'd4;
  assign branchTarget = pcPlus4 + (immEX << 2);
  assign jumpTarget   = {pcPlus4[31:28], instrEX[25:0], 2'b00};

  always_comb begin
    if (j_alEX)
      exResult = pcPlus4;
    else if (l_uiEX)
      exResult = {immEX[15:0], 16'h0000};
    else
      exResult = aluOut;

    if (j_alEX)
      exWsel = RA_REG;
    else if (reg_dstEX)
      exWsel = rdIdx;
    else
      exWsel = rtIdx;
  end

  assign lu_stall = validEX && validMEM && memtoregMEM && (wselMEM != '0) &&
                    ((wselMEM == rsIdx) || ((wselMEM == rtIdx) && !alu_srcEX));

  assign takeBranch = jmpEX || jmprEX ||
                      (b_eqEX && (opA == rtVal)) || (b_neEX && (opA != rtVal));
  assign redirect   = validEX && !hold && !lu_stall && !haltEX && takeBranch;

  always_comb begin
    if (jmprEX)
      redirect_pc = opA;
    else if (jmpEX)
      redirect_pc = jumpTarget;
    else
      redirect_pc = branchTarget;
  end

  // Once halted, nothing new may reach memory, so every capture becomes a bubble.
  assign bubble = flush || lu_stall || halted;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      validMEM    <= 1'b0;
      rf_writeMEM <= 1'b0;
      memtoregMEM <= 1'b0;
      dRENMEM     <= 1'b0;
      dWENMEM     <= 1'b0;
      haltMEM     <= 1'b0;
      aluresMEM   <= '0;
      storedatMEM <= '0;
      wselMEM     <= '0;
      pcplus4MEM  <= RESET_PC4;
    end else if (!hold) begin
      if (bubble) begin
        validMEM    <= 1'b0;
        rf_writeMEM <= 1'b0;
        memtoregMEM <= 1'b0;
        dRENMEM     <= 1'b0;
        dWENMEM     <= 1'b0;
        haltMEM     <= 1'b0;
      end else begin
        validMEM    <= validEX;
        rf_writeMEM <= rf_writeEX && validEX;
        memtoregMEM <= memtoregEX && validEX;
        dRENMEM     <= dRENEX && validEX;
        dWENMEM     <= dWENEX && validEX;
        haltMEM     <= haltEX && validEX;
        aluresMEM   <= exResult;
        storedatMEM <= rtVal;
        wselMEM     <= exWsel;
        pcplus4MEM  <= pcPlus4;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      halted <= 1'b0;
    else if (haltMEM)
      halted <= 1'b1;
  end

endmodule

// File: doc/exmem_stage.md
Name: exmem_stage

Overview:
Execute stage plus EX/MEM pipeline latch of the 5-stage MIPS pipeline. It consumes the EX-side outputs of the ID/EX latch and forwards operands from its own MEM-side latch and from WB. It computes the ALU result, resolves branches and jumps (redirect to fetch), detects load-use hazards, and registers everything the memory stage needs.

Parameters:
RA_REG, 5'd31, destination register written by jal
RESET_PC4, 32'h0, reset value of pcplus4MEM

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  reset, asynchronous, active-high
validEX  in  1  ID/EX slot holds a real instruction
opEX  in  aluop_t  ALU operation
rdat1EX, rdat2EX  in  32  register operands read in decode
immEX  in  32  immediate, already extended in decode
pcEX, instrEX  in  32  instruction address and word
jmpEX, jmprEX, j_alEX, b_eqEX, b_neEX  in  1  jump, jr, jal, beq, bne
alu_srcEX, l_uiEX, reg_dstEX  in  1  immediate operand B, lui, rd-vs-rt destination
rf_writeEX, memtoregEX, dRENEX, dWENEX, haltEX  in  1  control passed to MEM
hold  in  1  downstream memory stall; freeze latch
flush  in  1  squash EX/MEM input (insert bubble)
wb_wen  in  1  WB stage writes register file
wb_wsel  in  5  WB destination
wb_wdat  in  32  WB write data
redirect  out  1  fetch must load redirect_pc
redirect_pc  out  32  branch/jump target
lu_stall  out  1  load-use stall; upstream holds IF/ID and ID/EX
validMEM, rf_writeMEM, memtoregMEM, dRENMEM, dWENMEM, haltMEM  out  1  latched control
aluresMEM  out  32  ALU result, or pc+4 for jal
storedatMEM  out  32  forwarded rt operand for sw
wselMEM  out  5  destination register
pcplus4MEM  out  32  pcEX+4
halted  out  1  sticky halt flag

Behaviour:
- Reset: asynchronous, active-high. All MEM outputs are 0, pcplus4MEM is RESET_PC4, halted is 0. Reset asserted mid-operation discards the latched instruction immediately.
- Forwarding for each source (rs = instr[25:21], rt = instr[20:16]):
  - From MEM if validMEM && rf_writeMEM && !memtoregMEM && wselMEM == src && src != 0.
  - Otherwise from WB if wb_wen && wb_wsel == src && src != 0.
  - Otherwise the decode value.
  - MEM has priority over WB. Register 0 always reads as decoded.
- Load-use: lu_stall = validEX && validMEM && memtoregMEM && wselMEM != 0 && (wselMEM == rs || (wselMEM == rt && operand B uses rt)).
- Operand B is immEX when alu_srcEX=1. Stores always use forwarded rt for storedatMEM.
- ALU uses the existing aluop_t semantics, 32-bit wrap, overflow ignored.
  - l_uiEX: result = {immEX[15:0], 16'h0}.
  - j_alEX: result = pcEX+4.
- Destination: j_alEX gives RA_REG. Otherwise reg_dstEX selects instr[15:11], else instr[20:16].
- Targets:
  - branch = pcEX + 4 + (immEX << 2)
  - j/jal = {pcEX+4[31:28], instr[25:0], 2'b00}
  - jr = forwarded rs
- redirect = validEX && !hold && !lu_stall && !haltEX && (jmpEX || jmprEX || (b_eqEX && A==B) || (b_neEX && A!=B)). Branch comparison uses forwarded rs/rt.
- Latch update at each rising edge, in priority order:
  1. hold=1: all MEM regs keep their value. hold overrides flush and lu_stall.
  2. flush=1 or lu_stall=1: bubble. validMEM=0 and all write/enable controls 0; data fields don't-care.
  3. Otherwise: capture. validMEM=validEX. Controls are ANDed with validEX.
- Latency: 1 cycle EX→MEM. Branch redirect is combinational in EX, giving a 2-slot penalty handled upstream.
- halted sets when haltMEM=1 at a clock edge. It clears only on RST.
- While halted=1, the latch captures only bubbles.
- Simultaneous hold and lu_stall: hold wins; lu_stall stays asserted and takes effect once hold drops.

Decomposition:
- cpu_types_pkg:
  - existing aluop_t, word_t, regbits_t
  - new fwd_sel_t enum: FWD_NONE, FWD_MEM, FWD_WB
  - new constant RA_REG
- Sub-module: reuse the existing alu (inputs portA, portB, aluop; output outputPort). Forwarding and hazard logic stays inline.

Test Plan:
1. Reset mid-op: assert RST asynchronously while validMEM=1, rf_writeMEM=1 -> all MEM outputs are 0 before the next edge; halted=0.
2. MEM forward: add $3,$1,$2 with rdat1=5, rdat2=7 -> aluresMEM=12. Next, sub $4,$3,$1 with stale rdat1EX=0 -> aluresMEM=7.
3. Load-use: lw $5 in MEM, add $6,$5,$0 in EX -> lu_stall=1 for one cycle and validMEM=0 bubble. Next cycle the WB forward of wb_wdat=0x2A gives aluresMEM=0x2A.
4. Branch: beq at pcEX=0x100, immEX=4, A==B=9 -> redirect=1, redirect_pc=0x114. Same with hold=1 -> redirect=0 and latch unchanged. bne with equal operands -> redirect=0.
5. jal at pcEX=0x200, instr[25:0]=0x40 -> redirect_pc=0x100, wselMEM=31, aluresMEM=0x204, rf_writeMEM=1.
6. halt with hold: haltEX=1 and hold=1 for 3 cycles -> haltMEM stays 0. After release, haltMEM=1 next edge, then halted=1 sticky; later captures are bubbles.
